// File: rtl/shot_clock_countdown_pkg.sv
// Shared scoreboard definitions: FSM state encoding, default shot-clock
// values and the BCD digit type used by the display path.
package shot_clock_countdown_pkg;

  localparam int SHOT_FULL  = 24;
  localparam int SHOT_RESET = 14;
  localparam int CLK_HZ     = 50000000;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_BUZZ   = 2'd3
  } state_e;

endpackage

// File: rtl/bin_to_bcd_2digit.sv
// Combinational 7-bit binary to two BCD digits; values above 99 show 9/9.
module bin_to_bcd_2digit
  import shot_clock_countdown_pkg::*;
(
  input  logic [6:0] bin,
  output bcd_t       tens,
  output bcd_t       units
);

  always_comb begin
    tens  = 4'd9;
    units = 4'd9;
    if (bin <= 7'd99) begin
      tens  = 4'(bin / 7'd10);
      units = 4'(bin % 7'd10);
    end
  end

endmodule

// File: rtl/shot_clock_countdown.sv
// Shot-clock countdown: two presets, prescaled one-per-second stepping,
// start/pause control, timed buzzer and sticky expired flag.
//
// state  | meaning
// IDLE   | count holds, waiting for start
// RUN    | prescaler advances, count steps down on each tick
// PAUSED | count and prescaler frozen, partial second kept
// BUZZ   | count is 0, buzzer on for BUZZ_STEPS ticks
module shot_clock_countdown
  import shot_clock_countdown_pkg::*;
#(
  parameter int WIDTH      = 5,
  parameter int PRESET_A   = SHOT_FULL,
  parameter int PRESET_B   = SHOT_RESET,
  parameter int CLK_DIV    = CLK_HZ,
  parameter int BUZZ_STEPS = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count_out,
  output bcd_t             bcd_tens,
  output bcd_t             bcd_units,
  output logic             running,
  output logic             expired,
  output logic             buzzer
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] RUN    = ST_RUN;
  localparam logic [1:0] PAUSED = ST_PAUSED;
  localparam logic [1:0] BUZZ   = ST_BUZZ;

  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BUZZ_STEPS + 1);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0]    BUZZ_LAST  = BW'(BUZZ_STEPS - 1);
  localparam logic [WIDTH-1:0] VAL_A      = WIDTH'(PRESET_A);
  localparam logic [WIDTH-1:0] VAL_B      = WIDTH'(PRESET_B);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  logic [1:0]       state;
  logic [PW-1:0]    presc;
  logic [BW-1:0]    buzz_cnt;
  logic [WIDTH-1:0] count;
  logic             tick;

  assign tick = ((state == RUN) || (state == BUZZ)) && (presc == PRESC_LAST);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      presc    <= '0;
      buzz_cnt <= '0;
      count    <= '0;
      expired  <= 1'b0;
      buzzer   <= 1'b0;
    end else if (load_a || load_b) begin
      count    <= load_a ? VAL_A : VAL_B;
      presc    <= '0;
      buzz_cnt <= '0;
      expired  <= 1'b0;
      buzzer   <= 1'b0;
      if (state == BUZZ) state <= IDLE;
    end else begin
      case (state)
        IDLE, PAUSED: begin
          if (!pause && start && (count != '0)) state <= RUN;
        end
        RUN: begin
          // pause freezes the prescaler too, so a resume keeps the partial second
          if (pause) begin
            state <= PAUSED;
          end else if (tick) begin
            presc <= '0;
            if (count == ONE) begin
              count    <= '0;
              expired  <= 1'b1;
              buzzer   <= 1'b1;
              buzz_cnt <= '0;
              state    <= BUZZ;
            end else if (count != '0) begin
              count <= count - ONE;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        BUZZ: begin
          if (tick) begin
            presc <= '0;
            if (buzz_cnt == BUZZ_LAST) begin
              buzzer   <= 1'b0;
              buzz_cnt <= '0;
              state    <= IDLE;
            end else begin
              buzz_cnt <= buzz_cnt + BW'(1);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign count_out = count;
  assign running   = (state == RUN);

  bin_to_bcd_2digit u_bcd (
    .bin   (7'(count)),
    .tens  (bcd_tens),
    .units (bcd_units)
  );

endmodule

// File: tb/tb_shot_clock_countdown.sv
// Directed bench for shot_clock_countdown with CLK_DIV=4, BUZZ_STEPS=2.
module tb_shot_clock_countdown;

  localparam int WIDTH      = 5;
  localparam int PRESET_A   = 24;
  localparam int PRESET_B   = 14;
  localparam int CLK_DIV    = 4;
  localparam int BUZZ_STEPS = 2;

  logic             clock_in = 1'b0;
  logic             reset_n;
  logic             load_a, load_b, start, pause;
  logic [WIDTH-1:0] count_out;
  logic [3:0]       bcd_tens, bcd_units;
  logic             running, expired, buzzer;

  int errors = 0;
  int checks = 0;

  always #5 clock_in = ~clock_in;

  shot_clock_countdown #(
    .WIDTH      (WIDTH),
    .PRESET_A   (PRESET_A),
    .PRESET_B   (PRESET_B),
    .CLK_DIV    (CLK_DIV),
    .BUZZ_STEPS (BUZZ_STEPS)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .load_a    (load_a),
    .load_b    (load_b),
    .start     (start),
    .pause     (pause),
    .count_out (count_out),
    .bcd_tens  (bcd_tens),
    .bcd_units (bcd_units),
    .running   (running),
    .expired   (expired),
    .buzzer    (buzzer)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  initial begin
    if (PRESET_A >= (1 << WIDTH) || PRESET_B >= (1 << WIDTH)) begin
      $display("FAIL preset_width: preset does not fit in WIDTH=%0d", WIDTH);
      $fatal(1, "illegal preset parameters");
    end

    reset_n = 1'b0; load_a = 1'b0; load_b = 1'b0; start = 1'b0; pause = 1'b0;
    #3;
    chk("rst_count",   count_out, 0);
    chk("rst_running", running,   0);
    chk("rst_buzzer",  buzzer,    0);
    chk("rst_expired", expired,   0);
    chk("rst_bcd",     {bcd_tens, bcd_units}, 8'h00);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    // start with count 0 after reset is ignored
    start = 1'b1; cyc(2);
    chk("start0_running", running, 0);
    chk("start0_count",   count_out, 0);
    start = 1'b0;

    // full run 24 -> 0
    load_a = 1'b1; cyc(1); load_a = 1'b0;
    chk("loada_count", count_out, 24);
    chk("loada_bcd",   {bcd_tens, bcd_units}, 8'h24);
    chk("loada_idle",  running, 0);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("run_running", running, 1);
    cyc(3);
    chk("run_hold3", count_out, 24);
    cyc(1);
    chk("run_first_dec", count_out, 23);
    chk("run_bcd23", {bcd_tens, bcd_units}, 8'h23);
    cyc(91);
    chk("run_at_95_count",  count_out, 1);
    chk("run_at_95_buzzer", buzzer, 0);
    cyc(1);
    chk("zero_count",   count_out, 0);
    chk("zero_buzzer",  buzzer, 1);
    chk("zero_expired", expired, 1);
    chk("zero_running", running, 0);
    chk("zero_bcd",     {bcd_tens, bcd_units}, 8'h00);
    cyc(7);
    chk("buzz_last_cycle", buzzer, 1);
    cyc(1);
    chk("buzz_end", buzzer, 0);
    chk("buzz_end_expired", expired, 1);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("idle_after_buzz", running, 0);

    // pause from 14 keeps the partial second
    load_b = 1'b1; cyc(1); load_b = 1'b0;
    chk("loadb_count",   count_out, 14);
    chk("loadb_bcd",     {bcd_tens, bcd_units}, 8'h14);
    chk("loadb_expired", expired, 0);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(6);
    chk("pre_pause_count", count_out, 13);
    pause = 1'b1; cyc(1);
    chk("paused_running", running, 0);
    cyc(20);
    chk("paused_count", count_out, 13);
    pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
    chk("resume_running", running, 1);
    cyc(1);
    chk("resume_plus1", count_out, 13);
    cyc(1);
    chk("resume_plus2", count_out, 12);

    // load during RUN at count 5 with start held
    cyc(28);
    chk("run_to_5", count_out, 5);
    cyc(2);
    load_a = 1'b1; start = 1'b1; cyc(1); load_a = 1'b0;
    chk("runload_count",   count_out, 24);
    chk("runload_running", running, 1);
    cyc(3);
    chk("runload_hold3", count_out, 24);
    cyc(1);
    chk("runload_dec", count_out, 23);

    // both loads together, then pause+start on a tick edge
    load_a = 1'b1; load_b = 1'b1; cyc(1); load_a = 1'b0; load_b = 1'b0;
    chk("both_load", count_out, 24);
    cyc(3);
    pause = 1'b1; cyc(1);
    chk("pause_on_tick_count",   count_out, 24);
    chk("pause_on_tick_running", running, 0);
    cyc(8);
    chk("pause_start_hold", count_out, 24);
    pause = 1'b0; cyc(1);
    chk("resume2_running", running, 1);
    chk("resume2_count",   count_out, 24);
    start = 1'b0; cyc(1);
    chk("resume2_dec", count_out, 23);

    // async reset mid-BUZZ
    cyc(92);
    chk("buzz2_count",  count_out, 0);
    chk("buzz2_buzzer", buzzer, 1);
    cyc(2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_buzzer",  buzzer, 0);
    chk("async_expired", expired, 0);
    chk("async_count",   count_out, 0);
    chk("async_running", running, 0);
    cyc(2);
    reset_n = 1'b1;
    start = 1'b1; cyc(2); start = 1'b0;
    chk("post_rst_start_running", running, 0);

    // load during BUZZ
    load_b = 1'b1; cyc(1); load_b = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(56);
    chk("buzz3_count",  count_out, 0);
    chk("buzz3_buzzer", buzzer, 1);
    cyc(3);
    load_a = 1'b1; cyc(1); load_a = 1'b0;
    chk("buzzload_buzzer",  buzzer, 0);
    chk("buzzload_expired", expired, 0);
    chk("buzzload_running", running, 0);
    chk("buzzload_count",   count_out, 24);
    cyc(8);
    chk("buzzload_idle_hold", count_out, 24);
    chk("buzzload_buzz_off",  buzzer, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
